// File: rtl/fir_mac_pkg.sv
// Shared types, default widths and arithmetic helpers for the FIR MAC engine.
// Holds the FSM state enum plus saturate and round-half-up helpers.
package fir_mac_pkg;

    localparam int MAX_TAPS_D  = 1024;
    localparam int DW_D        = 16;
    localparam int COEF_FRAC_D = 15;
    localparam int ACC_W_D     = 42;

    typedef enum logic [2:0] {
        CLEAR,
        IDLE,
        LOAD,
        MAC,
        FINAL
    } fir_state_e;

    // Adds one half LSB of the post-shift result (round half up).
    function automatic logic signed [63:0] fir_round(
        input logic signed [63:0] v,
        input int                 frac
    );
        return v + (64'sd1 <<< (frac - 1));
    endfunction

    // Clamps v to the signed range of a w-bit word.
    function automatic logic signed [63:0] fir_sat(
        input logic signed [63:0] v,
        input int                 w
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/fir_hist_ram.sv
// Sample history store: DEPTH x DW simple dual-port RAM, one write port,
// one registered read port (1-cycle latency, old data on collision).
// Ports: clk; i_we/i_waddr/i_wdata write side; i_raddr in, o_rdata out.
module fir_hist_ram
    import fir_mac_pkg::*;
#(
    parameter int DEPTH = MAX_TAPS_D,
    parameter int DW    = DW_D,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/fir_mem_mac.sv
// Streaming FIR engine: fetches one tap per cycle from the coefficient RAM,
// multiply-accumulates it against the sample history, emits one output per input.
// Ports: clk/reset (sync, active-high); ctrl_enable/ctrl_ntaps control;
// in_* and out_* valid/ready streams; mem_* coefficient RAM master; busy status.
// Build option FIR_MAC_ROUND_EN: round half up before the shift instead of truncating.
module fir_mem_mac
    import fir_mac_pkg::*;
#(
    parameter int MAX_TAPS  = MAX_TAPS_D,
    parameter int DW        = DW_D,
    parameter int COEF_FRAC = COEF_FRAC_D,
    parameter int ACC_W     = ACC_W_D,
    localparam int AW       = $clog2(MAX_TAPS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ctrl_enable,
    input  logic [9:0]           ctrl_ntaps,
    input  logic signed [DW-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic signed [DW-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [9:0]           mem_address,
    output logic                 mem_chipselect,
    output logic                 mem_clken,
    output logic                 mem_write,
    output logic [31:0]          mem_writedata,
    output logic [3:0]           mem_byteenable,
    input  logic [31:0]          mem_readdata,
    output logic                 busy
);

    fir_state_e r_state;
    fir_state_e w_state_nx;

    logic [AW-1:0]          r_clr;
    logic [AW-1:0]          r_wr_ptr;
    logic [10:0]            r_n;
    logic [10:0]            r_k;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [DW-1:0]   r_out;
    logic                   r_out_valid;

    logic                   w_can_acc;
    logic                   w_accept;
    logic [10:0]            w_n_lat;
    logic [10:0]            w_k1;
    logic                   w_we;
    logic [AW-1:0]          w_waddr;
    logic [DW-1:0]          w_wdata;
    logic [AW-1:0]          w_raddr;
    logic [DW-1:0]          w_hist_rd;
    logic signed [DW-1:0]   w_samp;
    logic signed [DW-1:0]   w_coef;
    logic signed [2*DW-1:0] w_prod;
    logic signed [ACC_W-1:0] w_prod_ext;
    logic signed [63:0]     w_ext;
    logic signed [63:0]     w_pre;
    logic signed [63:0]     w_shift;
    logic signed [63:0]     w_sat;
    logic                   w_unused;

    fir_hist_ram #(
        .DEPTH (MAX_TAPS),
        .DW    (DW)
    ) u_hist (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (w_raddr),
        .o_rdata (w_hist_rd)
    );

    // A held output may be consumed in the same cycle a new sample is accepted.
    assign w_can_acc = ctrl_enable & (~r_out_valid | out_ready);
    assign w_accept  = (r_state == IDLE) & in_valid & w_can_acc;
    assign w_k1      = r_k + 11'd1;

    always_comb begin
        if (ctrl_ntaps == 10'd0) begin
            w_n_lat = 11'd1;
        end else if ({1'b0, ctrl_ntaps} > 11'(MAX_TAPS)) begin
            w_n_lat = 11'(MAX_TAPS);
        end else begin
            w_n_lat = {1'b0, ctrl_ntaps};
        end
    end

    // Both operands are registered reads that line up with tap r_k.
    assign w_coef     = mem_readdata[DW-1:0];
    assign w_samp     = w_hist_rd;
    assign w_prod     = w_coef * w_samp;
    assign w_prod_ext = {{(ACC_W-2*DW){w_prod[2*DW-1]}}, w_prod};
    assign w_unused   = ^mem_readdata[31:DW];

    assign w_ext = {{(64-ACC_W){r_acc[ACC_W-1]}}, r_acc};
`ifdef FIR_MAC_ROUND_EN
    assign w_pre = fir_round(w_ext, COEF_FRAC);
`else
    assign w_pre = w_ext;
`endif
    assign w_shift = w_pre >>> COEF_FRAC;
    assign w_sat   = fir_sat(w_shift, DW);

    always_comb begin
        w_state_nx     = r_state;
        in_ready       = 1'b0;
        mem_chipselect = 1'b0;
        mem_clken      = 1'b0;
        mem_address    = 10'd0;
        w_we           = 1'b0;
        w_waddr        = r_clr;
        w_wdata        = '0;
        w_raddr        = r_wr_ptr;
        unique case (r_state)
            CLEAR: begin
                w_we = 1'b1;
                if (r_clr == AW'(MAX_TAPS - 1)) begin
                    w_state_nx = IDLE;
                end
            end
            IDLE: begin
                in_ready = w_can_acc;
                if (w_accept) begin
                    w_we       = 1'b1;
                    w_waddr    = r_wr_ptr;
                    w_wdata    = in_data;
                    w_state_nx = LOAD;
                end
            end
            LOAD: begin
                mem_chipselect = 1'b1;
                mem_clken      = 1'b1;
            end
            MAC: begin
                mem_chipselect = 1'b1;
                mem_clken      = 1'b1;
                // Prefetch tap k+1 while it exists; history walks backwards.
                if (w_k1 < r_n) begin
                    mem_address = w_k1[9:0];
                end
                w_raddr = r_wr_ptr - w_k1[AW-1:0];
                if (w_k1 == r_n) begin
                    w_state_nx = FINAL;
                end
            end
            FINAL: begin
                w_state_nx = IDLE;
            end
            default: begin
                w_state_nx = CLEAR;
            end
        endcase
        if (r_state == LOAD) begin
            w_state_nx = MAC;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= CLEAR;
            r_clr       <= '0;
            r_wr_ptr    <= '0;
            r_n         <= 11'd1;
            r_k         <= 11'd0;
            r_acc       <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            if (r_out_valid & out_ready) begin
                r_out_valid <= 1'b0;
            end
            unique case (r_state)
                CLEAR: begin
                    r_clr <= r_clr + 1'b1;
                end
                IDLE: begin
                    if (w_accept) begin
                        r_n <= w_n_lat;
                    end
                end
                LOAD: begin
                    r_acc <= '0;
                    r_k   <= 11'd0;
                end
                MAC: begin
                    r_acc <= r_acc + w_prod_ext;
                    r_k   <= w_k1;
                end
                FINAL: begin
                    r_out       <= w_sat[DW-1:0];
                    r_out_valid <= 1'b1;
                    r_wr_ptr    <= r_wr_ptr + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign out_data       = r_out;
    assign out_valid      = r_out_valid;
    assign busy           = (r_state != IDLE);
    assign mem_write      = 1'b0;
    assign mem_writedata  = 32'd0;
    assign mem_byteenable = 4'hF;

endmodule

// File: tb/tb_fir_mem_mac.sv
// Randomized self-checking bench for fir_mem_mac against a direct
// convolution model over the sample list and coefficient table.
module tb_fir_mem_mac;

    logic               clk;
    logic               reset;
    logic               ctrl_enable;
    logic [9:0]         ctrl_ntaps;
    logic signed [15:0] in_data;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] out_data;
    logic               out_valid;
    logic               out_ready;
    logic [9:0]         mem_address;
    logic               mem_chipselect;
    logic               mem_clken;
    logic               mem_write;
    logic [31:0]        mem_writedata;
    logic [3:0]         mem_byteenable;
    logic [31:0]        mem_readdata;
    logic               busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int coef [1024];
    int hist [$];

    fir_mem_mac dut (
        .clk            (clk),
        .reset          (reset),
        .ctrl_enable    (ctrl_enable),
        .ctrl_ntaps     (ctrl_ntaps),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_clken      (mem_clken),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_byteenable (mem_byteenable),
        .mem_readdata   (mem_readdata),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Coefficient RAM: 1-cycle read while enabled, junk in the upper half.
    always @(posedge clk) begin
        if (mem_chipselect && mem_clken) begin
            mem_readdata <= {16'($urandom), 16'(coef[mem_address])};
        end
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint model_out(input int n);
        longint acc;
        int     sz;
        acc = 0;
        sz  = hist.size();
        for (int k = 0; k < n; k++) begin
            if (k < sz) begin
                acc += longint'(coef[k]) * longint'(hist[sz-1-k]);
            end
        end
`ifdef FIR_MAC_ROUND_EN
        acc += 64'sd16384;
`endif
        acc = acc >>> 15;
        if (acc > 32767) acc = 32767;
        else if (acc < -32768) acc = -32768;
        return acc;
    endfunction

    function automatic int rnd16();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    task automatic do_reset();
        int g;
        bit seen_ov;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_cs", mem_chipselect, 0);
        chk("rst_clken", mem_clken, 0);
        chk("rst_addr", mem_address, 0);
        chk("rst_busy", busy, 1);
        chk("mem_write", mem_write, 0);
        chk("mem_wdata", mem_writedata, 0);
        chk("mem_be", mem_byteenable, 15);
        reset = 1'b0;
        hist.delete();
        #1;
        g = 0;
        seen_ov = 1'b0;
        while (!in_ready && g < 3000) begin
            if (!busy) seen_ov = 1'b1;
            if (out_valid) seen_ov = 1'b1;
            @(posedge clk);
            #1;
            g++;
        end
        chk("clear_len", g, 1024);
        chk("clear_busy_ov", seen_ov, 0);
        chk("idle_busy", busy, 0);
    endtask

    task automatic run_sample(input int x, input int nt, input int hold, input bit drop_en);
        int     n;
        int     g;
        int     acc_cyc;
        longint exp;
        n = (nt == 0) ? 1 : ((nt > 1024) ? 1024 : nt);
        ctrl_ntaps = 10'(nt);
        #1;
        g = 0;
        while (!in_ready && g < 3000) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (!in_ready) begin
            chk("ready_timeout", 0, 1);
            return;
        end
        in_valid = 1'b1;
        in_data  = 16'(x);
        acc_cyc  = cyc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        hist.push_back(x);
        exp = model_out(n);
        ctrl_ntaps = 10'($urandom);
        out_ready  = (hold == 0);
        if (drop_en) begin
            repeat (3) begin
                @(posedge clk);
                #1;
            end
            ctrl_enable = 1'b0;
        end
        g = 0;
        while (!out_valid && g < 2000) begin
            @(posedge clk);
            #1;
            g++;
        end
        chk("latency", cyc - acc_cyc, n + 3);
        chk("data", longint'(out_data), exp);
        if (hold > 0) begin
            repeat (hold) begin
                @(posedge clk);
                #1;
            end
            chk("hold_valid", out_valid, 1);
            chk("hold_data", longint'(out_data), exp);
            chk("hold_ready", in_ready, 0);
        end
        if (drop_en) begin
            chk("drop_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        #1;
    endtask

    initial begin
        int nt;
        int hold;
        int g;
        bit seen;
        reset       = 1'b1;
        ctrl_enable = 1'b1;
        ctrl_ntaps  = 10'd4;
        in_valid    = 1'b0;
        in_data     = '0;
        out_ready   = 1'b1;
        for (int i = 0; i < 1024; i++) coef[i] = 0;

        do_reset();

        // Impulse through four taps.
        coef[0] = 16384;
        coef[1] = 8192;
        coef[2] = -8192;
        coef[3] = 4096;
        run_sample(32767, 4, 0, 0);
        for (int i = 0; i < 4; i++) run_sample(0, 4, 0, 0);

        // Backpressure then same-cycle handoff.
        for (int i = 0; i < 8; i++) coef[i] = int'($urandom_range(0, 8191)) - 4096;
        run_sample(rnd16(), 8, 5, 0);
        chk("b2b_valid", out_valid, 1);
        chk("b2b_ready", in_ready, 1);
        run_sample(rnd16(), 8, 0, 0);

        // Saturation both ways.
        coef[0] = 32767;
        coef[1] = 32767;
        run_sample(32767, 2, 0, 0);
        run_sample(32767, 2, 0, 0);
        run_sample(-32768, 2, 0, 0);
        run_sample(-32768, 2, 0, 0);

        // acc = 3*2^14: truncates to 1, rounds to 2.
        coef[0] = 24576;
        run_sample(2, 1, 0, 0);
        coef[0] = rnd16();
        run_sample(rnd16(), 0, 0, 0);

        // Long random run that wraps the history pointer.
        for (int i = 0; i < 1100; i++) begin
            if (i % 100 == 0) begin
                for (int k = 0; k < 1024; k++) begin
                    coef[k] = (i % 200 == 0) ? rnd16() : int'($urandom_range(0, 4095)) - 2048;
                end
            end
            nt   = (i == 500 || i == 1050) ? 1023 : int'($urandom_range(0, 16));
            hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            run_sample(rnd16(), nt, hold, 0);
        end

        // Enable drop mid-sample.
        run_sample(rnd16(), 8, 0, 1);
        in_valid = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (in_ready || busy || out_valid) seen = 1'b1;
        end
        chk("drop_no_accept", seen, 0);
        in_valid    = 1'b0;
        ctrl_enable = 1'b1;
        #1;

        // Reset during MAC aborts and reruns CLEAR.
        ctrl_ntaps = 10'd20;
        #1;
        g = 0;
        while (!in_ready && g < 100) begin
            @(posedge clk);
            #1;
            g++;
        end
        chk("pre_rst_ready", in_ready, 1);
        in_valid = 1'b1;
        in_data  = 16'(rnd16());
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        chk("mac_busy", busy, 1);
        do_reset();

        // History must be zero after the rerun CLEAR.
        for (int k = 0; k < 16; k++) coef[k] = rnd16();
        for (int i = 0; i < 20; i++) run_sample(rnd16(), 16, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
